// File: rtl/uart_tx_seq.sv
// UART transmit frame sequencer: drives the 4:1 line mux select/enable,
// owns the baud counter, data shift register, parity and byte handshake.
module uart_tx_seq #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx_busy,
  output logic [1:0]           mux_sel,
  output logic                 mux_en,
  output logic                 ser_data,
  output logic                 par_bit
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_EN > 1 ||
      PARITY_ODD > 1 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_seq: illegal parameter value");
  end

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b11;
  localparam logic [1:0] SEL_STOP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;

  assign ser_data = shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mux_en   <= 1'b0;
      mux_sel  <= SEL_STOP;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      baud     <= '0;
      bit_cnt  <= '0;
    end else begin
      mux_en  <= 1'b1;
      tx_done <= 1'b0;
      if (state == S_IDLE) begin
        // ready rises on the first edge after reset and stays up while idle
        tx_ready <= 1'b1;
        if (tx_ready && tx_valid) begin
          shift    <= tx_data;
          par_bit  <= (^tx_data) ^ 1'(PARITY_ODD);
          state    <= S_START;
          mux_sel  <= SEL_START;
          tx_ready <= 1'b0;
          tx_busy  <= 1'b1;
          baud     <= '0;
        end
      end else if (baud != BAUD_LAST) begin
        baud <= baud + 1'b1;
      end else begin
        baud <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            mux_sel <= SEL_DATA;
            bit_cnt <= '0;
          end
          S_DATA: begin
            shift <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state   <= S_PARITY;
                mux_sel <= SEL_PARITY;
              end else begin
                state   <= S_STOP;
                mux_sel <= SEL_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            mux_sel <= SEL_STOP;
            bit_cnt <= '0;
          end
          S_STOP: begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt  <= '0;
              state    <= S_IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: begin
            state   <= S_IDLE;
            mux_sel <= SEL_STOP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Scoreboard bench for uart_tx_seq across five parameter sets; the expected
// line waveform is built per byte as a list of bit symbols, each CLKS_PER_BIT long.
module tb_uart_tx_seq;

  typedef struct packed {
    logic [1:0] sel;
    logic       lvl;
  } sym_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, g, $time, act, exp);
    end
  endtask

  // Line level as seen at the 4:1 mux output for a given select.
  function automatic logic line_of(input logic [1:0] sel, input logic ser, input logic par);
    case (sel)
      2'b00:   return 1'b0;
      2'b01:   return ser;
      2'b11:   return par;
      default: return 1'b1;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : gi
    localparam int unsigned C  = (g == 4) ? 2 : 4;
    localparam int unsigned DB = (g == 4) ? 5 : 8;
    localparam int unsigned PE = (g == 2 || g == 3) ? 0 : 1;
    localparam int unsigned PO = (g == 1 || g == 4) ? 1 : 0;
    localparam int unsigned SB = (g == 3 || g == 4) ? 2 : 1;
    localparam int unsigned NC = (1 + DB + PE + SB) * C;

    logic          rst_n, tx_valid, tx_ready, tx_done, tx_busy, mux_en, ser_data, par_bit;
    logic [DB-1:0] tx_data;
    logic [1:0]    mux_sel;
    logic [DB-1:0] exp_q[$];
    bit            fin = 1'b0;

    uart_tx_seq #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (DB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO),
      .STOP_BITS   (SB)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_done (tx_done),
      .tx_busy (tx_busy),
      .mux_sel (mux_sel),
      .mux_en  (mux_en),
      .ser_data(ser_data),
      .par_bit (par_bit)
    );

    // ---------------- monitor / scoreboard ----------------
    typedef enum {M_PRE, M_IDLE, M_FRAME} mst_t;
    mst_t        mst = M_PRE;
    int unsigned k = 0;
    logic        exp_done = 1'b0;
    logic        exp_par = 1'b0;
    logic [DB-1:0] cur;
    sym_t        syms[$];
    sym_t        sym;

    always @(negedge clk) begin
      if (!rst_n) begin
        check("rst_en",    g, 8'(mux_en),   8'h0);
        check("rst_sel",   g, 8'(mux_sel),  8'h2);
        check("rst_ready", g, 8'(tx_ready), 8'h0);
        check("rst_busy",  g, 8'(tx_busy),  8'h0);
        check("rst_done",  g, 8'(tx_done),  8'h0);
        check("rst_ser",   g, 8'(ser_data), 8'h0);
        check("rst_par",   g, 8'(par_bit),  8'h0);
        mst = M_PRE;
        exp_done = 1'b0;
      end else if (mst == M_PRE) begin
        check("pre_en",    g, 8'(mux_en),   8'h0);
        check("pre_ready", g, 8'(tx_ready), 8'h0);
        mst = M_IDLE;
      end else begin
        if (mst == M_FRAME) begin
          k++;
          if (k <= NC) begin
            sym = syms[(k - 1) / C];
            check("frm_sel",   g, 8'(mux_sel), 8'(sym.sel));
            check("frm_line",  g, 8'(line_of(mux_sel, ser_data, par_bit)), 8'(sym.lvl));
            check("frm_par",   g, 8'(par_bit),  8'(exp_par));
            check("frm_busy",  g, 8'(tx_busy),  8'h1);
            check("frm_ready", g, 8'(tx_ready), 8'h0);
            check("frm_done",  g, 8'(tx_done),  8'h0);
            check("frm_en",    g, 8'(mux_en),   8'h1);
          end else begin
            mst = M_IDLE;
            exp_done = 1'b1;
          end
        end
        if (mst == M_IDLE) begin
          check("idle_en",    g, 8'(mux_en),   8'h1);
          check("idle_ready", g, 8'(tx_ready), 8'h1);
          check("idle_busy",  g, 8'(tx_busy),  8'h0);
          check("idle_line",  g, 8'(line_of(mux_sel, ser_data, par_bit)), 8'h1);
          check("idle_sel",   g, 8'(mux_sel),  8'h2);
          check("done_pulse", g, 8'(tx_done),  8'(exp_done));
          exp_done = 1'b0;
          if (tx_valid) begin
            check("queue_depth", g, 8'(exp_q.size()), 8'h1);
            if (exp_q.size() > 0) begin
              cur = exp_q.pop_front();
              exp_par = (^cur) ^ 1'(PO);
              syms.delete();
              syms.push_back('{2'b00, 1'b0});
              for (int unsigned i = 0; i < DB; i++) syms.push_back('{2'b01, cur[i]});
              if (PE != 0) syms.push_back('{2'b11, exp_par});
              for (int unsigned i = 0; i < SB; i++) syms.push_back('{2'b10, 1'b1});
              k = 0;
              mst = M_FRAME;
            end
          end
        end
      end
    end

    // ---------------- stimulus ----------------
    // Entered #1 after an edge; returns #1 after the edge that starts frame
    // cycle 1 (hold_valid) or first idle cycle (otherwise / after abort).
    task automatic send_frame(input logic [7:0] v, input bit hold_valid, input int unsigned abort_cyc);
      int unsigned wc = 0;
      logic [31:0] r;
      tx_data  = v[DB-1:0];
      tx_valid = 1'b1;
      exp_q.push_back(v[DB-1:0]);
      @(negedge clk);
      while (!(tx_ready && tx_valid) && wc < 4 * NC) begin
        wc++;
        @(negedge clk);
      end
      if (wc >= 4 * NC) check("accept_timeout", g, 8'(tx_ready), 8'h1);
      @(posedge clk); #1;
      if (!hold_valid) begin
        tx_valid = 1'b0;
        for (int unsigned j = 1; j <= NC; j++) begin
          if (j == abort_cyc) begin
            tx_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check("abort_en",    g, 8'(mux_en),  8'h0);
            check("abort_busy",  g, 8'(tx_busy), 8'h0);
            check("abort_done",  g, 8'(tx_done), 8'h0);
            check("abort_sel",   g, 8'(mux_sel), 8'h2);
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            break;
          end
          r = $urandom;
          tx_data  = r[DB-1:0];
          tx_valid = (j + 1 < NC) && ($urandom_range(5) == 0);
          @(posedge clk); #1;
        end
        tx_valid = 1'b0;
      end
    endtask

    initial begin
      logic [7:0] v;
      bit hold;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      for (int unsigned i = 0; i < 35; i++) begin
        case (i)
          0:       begin v = 8'hA5; hold = 1'b0; end
          1:       begin v = 8'h01; hold = 1'b0; end
          2:       begin v = 8'h03; hold = 1'b0; end
          3:       begin v = 8'h55; hold = 1'b1; end
          4:       begin v = 8'h0F; hold = 1'b0; end
          default: begin v = 8'($urandom); hold = (i < 34) && ($urandom_range(2) == 0); end
        endcase
        send_frame(v, hold, 0);
        if (!hold) repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      end
      repeat (4) @(posedge clk);
      #1;
      send_frame(8'hFF, 1'b0, 4 * C + 2);
      repeat (5) @(posedge clk);
      #1;
      send_frame(8'h00, 1'b0, 0);
      repeat (5) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int unsigned cyc = 0;
    bit all_fin = 1'b0;
    while (!all_fin && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      all_fin = gi[0].fin & gi[1].fin & gi[2].fin & gi[3].fin & gi[4].fin;
    end
    check("run_complete", 0, 8'(all_fin), 8'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
